// File: rtl/control_pipe.sv
// RV32I control decode with D->E->M->W control pipeline and E-stage branch resolution.
// Optional RV32M decode is enabled by defining CTRL_MULDIV_EN.
module control_pipe #(
    parameter int ALUCTRL_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           Op,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 flush_e,
    input  logic                 zero_e,
    input  logic                 lt_e,
    input  logic                 ltu_e,
    output logic [2:0]           ImmSrcD,
    output logic                 RegWriteE,
    output logic                 RegWriteM,
    output logic                 RegWriteW,
    output logic                 MemWriteE,
    output logic                 MemWriteM,
    output logic [1:0]           ResultSrcE,
    output logic [1:0]           ResultSrcM,
    output logic [1:0]           ResultSrcW,
    output logic                 ALUSrcE,
    output logic                 ALUSrcAE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 BranchE,
    output logic                 JumpE,
    output logic                 IllegalE,
    output logic                 PCSrcE
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
`ifdef CTRL_MULDIV_EN
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
`endif

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_AND   = 5'd2;
    localparam logic [4:0] ALU_OR    = 5'd3;
    localparam logic [4:0] ALU_XOR   = 5'd4;
    localparam logic [4:0] ALU_SLT   = 5'd5;
    localparam logic [4:0] ALU_SLTU  = 5'd6;
    localparam logic [4:0] ALU_SLL   = 5'd7;
    localparam logic [4:0] ALU_SRL   = 5'd8;
    localparam logic [4:0] ALU_SRA   = 5'd9;
    localparam logic [4:0] ALU_PASSB = 5'd10;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    // A zeroed ctrl_t is a bubble: no writes, no redirect, not illegal.
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic [1:0] result_src;
        logic       alu_src;
        logic       alu_src_a;
        logic [4:0] alu_ctrl;
        logic       branch;
        logic       jump;
        logic       illegal;
    } ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic [1:0] result_src;
    } mctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
    } wctrl_t;

    // Base ALU operation selected by funct3 for register and immediate ALU ops.
    function automatic logic [4:0] f3_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  f3_alu = ALU_ADD;
            3'b001:  f3_alu = ALU_SLL;
            3'b010:  f3_alu = ALU_SLT;
            3'b011:  f3_alu = ALU_SLTU;
            3'b100:  f3_alu = ALU_XOR;
            3'b101:  f3_alu = ALU_SRL;
            3'b110:  f3_alu = ALU_OR;
            default: f3_alu = ALU_AND;
        endcase
    endfunction

    ctrl_t      dec_ctrl;
    logic       dec_legal;
    ctrl_t      e_d, e_q;
    logic [2:0] f3_e_d, f3_e_q;
    mctrl_t     m_d, m_q;
    wctrl_t     w_d, w_q;
    logic       br_cond;

    // Decode stage
    always_comb begin
        dec_ctrl  = '0;
        dec_legal = 1'b1;
        ImmSrcD   = IMM_I;
        case (Op)
            OP_R: begin
                dec_ctrl.reg_write = 1'b1;
                if (funct7 == F7_BASE) begin
                    dec_ctrl.alu_ctrl = f3_alu(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_ctrl.alu_ctrl = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_ctrl.alu_ctrl = ALU_SRA;
`ifdef CTRL_MULDIV_EN
                end else if (funct7 == F7_MULDIV) begin
                    dec_ctrl.alu_ctrl = 5'd16 + {2'b00, funct3};
`endif
                end else begin
                    dec_legal = 1'b0;
                end
            end
            OP_I: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_ctrl  = f3_alu(funct3);
                // Only the shift-immediates carry meaning in funct7.
                if (funct3 == 3'b001 && funct7 != F7_BASE) begin
                    dec_legal = 1'b0;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT) begin
                        dec_ctrl.alu_ctrl = ALU_SRA;
                    end else if (funct7 != F7_BASE) begin
                        dec_legal = 1'b0;
                    end
                end
            end
            OP_LOAD: begin
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.result_src = 2'd1;
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.alu_ctrl   = ALU_ADD;
            end
            OP_STORE: begin
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_ctrl  = ALU_ADD;
                ImmSrcD            = IMM_S;
            end
            OP_BRANCH: begin
                dec_ctrl.branch   = 1'b1;
                dec_ctrl.alu_ctrl = ALU_SUB;
                ImmSrcD           = IMM_B;
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    dec_legal = 1'b0;
                end
            end
            OP_JAL: begin
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.jump       = 1'b1;
                dec_ctrl.result_src = 2'd2;
                ImmSrcD             = IMM_J;
            end
            OP_JALR: begin
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.jump       = 1'b1;
                dec_ctrl.result_src = 2'd2;
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.alu_ctrl   = ALU_ADD;
            end
            OP_LUI: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_ctrl  = ALU_PASSB;
                ImmSrcD            = IMM_U;
            end
            OP_AUIPC: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_src_a = 1'b1;
                dec_ctrl.alu_ctrl  = ALU_ADD;
                ImmSrcD            = IMM_U;
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
        if (!dec_legal) begin
            dec_ctrl         = '0;
            dec_ctrl.illegal = 1'b1;
        end
    end

    always_comb begin
        e_d    = flush_e ? ctrl_t'('0) : dec_ctrl;
        f3_e_d = flush_e ? 3'b000 : funct3;
        m_d    = '{reg_write: e_q.reg_write, mem_write: e_q.mem_write, result_src: e_q.result_src};
        w_d    = '{reg_write: m_q.reg_write, result_src: m_q.result_src};
    end

    // D->E, E->M, M->W boundaries; reset wins over flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_q    <= '0;
            f3_e_q <= '0;
            m_q    <= '0;
            w_q    <= '0;
        end else begin
            e_q    <= e_d;
            f3_e_q <= f3_e_d;
            m_q    <= m_d;
            w_q    <= w_d;
        end
    end

    // Execute stage: branch resolution
    always_comb begin
        case (f3_e_q)
            3'b000:  br_cond = zero_e;
            3'b001:  br_cond = !zero_e;
            3'b100:  br_cond = lt_e;
            3'b101:  br_cond = !lt_e;
            3'b110:  br_cond = ltu_e;
            3'b111:  br_cond = !ltu_e;
            default: br_cond = 1'b0;
        endcase
        PCSrcE = e_q.jump | (e_q.branch & br_cond);
    end

    assign RegWriteE   = e_q.reg_write;
    assign MemWriteE   = e_q.mem_write;
    assign ResultSrcE  = e_q.result_src;
    assign ALUSrcE     = e_q.alu_src;
    assign ALUSrcAE    = e_q.alu_src_a;
    assign ALUControlE = ALUCTRL_W'(e_q.alu_ctrl);
    assign BranchE     = e_q.branch;
    assign JumpE       = e_q.jump;
    assign IllegalE    = e_q.illegal;

    assign RegWriteM   = m_q.reg_write;
    assign MemWriteM   = m_q.mem_write;
    assign ResultSrcM  = m_q.result_src;

    assign RegWriteW   = w_q.reg_write;
    assign ResultSrcW  = w_q.result_src;

endmodule

// File: tb/tb_control_pipe.sv
// Bench for control_pipe: instruction-level reference model compared every cycle,
// plus literal expectations for reset, load latency, branch redirect and flush/reset.
module tb_control_pipe;

    logic       clk = 1'b0;
    logic       rst, flush_e, zero_e, lt_e, ltu_e;
    logic [6:0] Op, funct7;
    logic [2:0] funct3;
    logic [2:0] ImmSrcD;
    logic       RegWriteE, RegWriteM, RegWriteW, MemWriteE, MemWriteM;
    logic [1:0] ResultSrcE, ResultSrcM, ResultSrcW;
    logic       ALUSrcE, ALUSrcAE, BranchE, JumpE, IllegalE, PCSrcE;
    logic [4:0] ALUControlE;

    int checks = 0;
    int failures = 0;

`ifdef CTRL_MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif

    control_pipe #(.ALUCTRL_W(5)) dut (
        .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7),
        .flush_e(flush_e), .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
        .ImmSrcD(ImmSrcD),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemWriteE(MemWriteE), .MemWriteM(MemWriteM),
        .ResultSrcE(ResultSrcE), .ResultSrcM(ResultSrcM), .ResultSrcW(ResultSrcW),
        .ALUSrcE(ALUSrcE), .ALUSrcAE(ALUSrcAE), .ALUControlE(ALUControlE),
        .BranchE(BranchE), .JumpE(JumpE), .IllegalE(IllegalE), .PCSrcE(PCSrcE)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rw;
        logic       mw;
        logic [1:0] rs;
        logic       asrc;
        logic       asrca;
        logic [4:0] alu;
        logic       br;
        logic       jmp;
        logic       ill;
        logic [2:0] f3;
    } ctl_t;

    // ALU code for funct3 of register/immediate ALU ops: add sll slt sltu xor srl or and.
    localparam logic [4:0] F3_ALU [8] = '{5'd0, 5'd7, 5'd5, 5'd6, 5'd4, 5'd8, 5'd3, 5'd2};

    function automatic ctl_t ref_decode(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        ctl_t c;
        bit ok;
        c  = '0;
        ok = 1'b1;
        case (op)
            7'b0110011: begin
                c.rw  = 1'b1;
                c.alu = F3_ALU[f3];
                if (f7 == 7'h20 && f3 == 3'd0) c.alu = 5'd1;
                else if (f7 == 7'h20 && f3 == 3'd5) c.alu = 5'd9;
                else if (f7 == 7'h01 && MULDIV) c.alu = 5'(16 + int'(f3));
                else if (f7 != 7'h00) ok = 1'b0;
            end
            7'b0010011: begin
                c.rw = 1'b1; c.asrc = 1'b1; c.alu = F3_ALU[f3];
                if (f3 == 3'd1 && f7 != 7'h00) ok = 1'b0;
                if (f3 == 3'd5) begin
                    if (f7 == 7'h20) c.alu = 5'd9;
                    else if (f7 != 7'h00) ok = 1'b0;
                end
            end
            7'b0000011: begin c.rw = 1'b1; c.rs = 2'd1; c.asrc = 1'b1; end
            7'b0100011: begin c.mw = 1'b1; c.asrc = 1'b1; end
            7'b1100011: begin c.br = 1'b1; c.alu = 5'd1; ok = (f3 != 3'd2 && f3 != 3'd3); end
            7'b1101111: begin c.jmp = 1'b1; c.rs = 2'd2; c.rw = 1'b1; end
            7'b1100111: begin c.jmp = 1'b1; c.rs = 2'd2; c.rw = 1'b1; c.asrc = 1'b1; end
            7'b0110111: begin c.rw = 1'b1; c.asrc = 1'b1; c.alu = 5'd10; end
            7'b0010111: begin c.rw = 1'b1; c.asrc = 1'b1; c.asrca = 1'b1; end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            c     = '0;
            c.ill = 1'b1;
        end else begin
            c.f3 = f3;
        end
        return c;
    endfunction

    function automatic logic [2:0] ref_imm(input logic [6:0] op);
        if (op == 7'b0100011) return 3'd1;
        if (op == 7'b1100011) return 3'd2;
        if (op == 7'b1101111) return 3'd3;
        if (op == 7'b0110111 || op == 7'b0010111) return 3'd4;
        return 3'd0;
    endfunction

    function automatic logic taken(input ctl_t c, input logic z, input logic lt, input logic ltu);
        if (c.jmp) return 1'b1;
        if (!c.br) return 1'b0;
        case (c.f3)
            3'd0: return z;      // beq
            3'd1: return !z;     // bne
            3'd4: return lt;     // blt
            3'd5: return !lt;    // bge
            3'd6: return ltu;    // bltu
            3'd7: return !ltu;   // bgeu
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference pipeline: each slot holds what that stage must show.
    ctl_t       exp_e;
    logic [2:0] exp_m;   // {mw, rs} plus rw kept separately
    logic       exp_m_rw, exp_m_mw;
    logic [1:0] exp_m_rs, exp_w_rs;
    logic       exp_w_rw;
    bit         model_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            exp_e = '0; exp_m_rw = 0; exp_m_mw = 0; exp_m_rs = 0; exp_w_rw = 0; exp_w_rs = 0;
        end else begin
            exp_w_rw = exp_m_rw; exp_w_rs = exp_m_rs;
            exp_m_rw = exp_e.rw; exp_m_mw = exp_e.mw; exp_m_rs = exp_e.rs;
            exp_e    = flush_e ? ctl_t'('0) : ref_decode(Op, funct3, funct7);
        end
        exp_m       = {exp_m_mw, exp_m_rs};
        model_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("ImmSrcD", ImmSrcD, ref_imm(Op));
            chk("RegWriteE", RegWriteE, exp_e.rw);
            chk("MemWriteE", MemWriteE, exp_e.mw);
            chk("ResultSrcE", ResultSrcE, exp_e.rs);
            chk("ALUSrcE", ALUSrcE, exp_e.asrc);
            chk("ALUSrcAE", ALUSrcAE, exp_e.asrca);
            chk("ALUControlE", ALUControlE, exp_e.alu);
            chk("BranchE", BranchE, exp_e.br);
            chk("JumpE", JumpE, exp_e.jmp);
            chk("IllegalE", IllegalE, exp_e.ill);
            chk("PCSrcE", PCSrcE, taken(exp_e, zero_e, lt_e, ltu_e));
            chk("RegWriteM", RegWriteM, exp_m_rw);
            chk("MemWriteM", MemWriteM, exp_m[2]);
            chk("ResultSrcM", ResultSrcM, exp_m[1:0]);
            chk("RegWriteW", RegWriteW, exp_w_rw);
            chk("ResultSrcW", ResultSrcW, exp_w_rs);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        Op = op; funct3 = f3; funct7 = f7;
    endtask

    localparam int NV = 38;
    // {Op, funct3, funct7}
    localparam logic [16:0] VEC [NV] = '{
        {7'b0110011, 3'd0, 7'h00}, {7'b0110011, 3'd0, 7'h20}, {7'b0110011, 3'd1, 7'h00},
        {7'b0110011, 3'd2, 7'h00}, {7'b0110011, 3'd3, 7'h00}, {7'b0110011, 3'd4, 7'h00},
        {7'b0110011, 3'd5, 7'h00}, {7'b0110011, 3'd5, 7'h20}, {7'b0110011, 3'd6, 7'h00},
        {7'b0110011, 3'd7, 7'h00}, {7'b0110011, 3'd3, 7'h01}, {7'b0110011, 3'd1, 7'h20},
        {7'b0110011, 3'd0, 7'h40}, {7'b0010011, 3'd0, 7'h55}, {7'b0010011, 3'd1, 7'h00},
        {7'b0010011, 3'd1, 7'h20}, {7'b0010011, 3'd5, 7'h20}, {7'b0010011, 3'd5, 7'h00},
        {7'b0010011, 3'd5, 7'h10}, {7'b0010011, 3'd4, 7'h7f}, {7'b0000011, 3'd2, 7'h00},
        {7'b0100011, 3'd2, 7'h00}, {7'b1100011, 3'd0, 7'h00}, {7'b1100011, 3'd1, 7'h00},
        {7'b1100011, 3'd2, 7'h00}, {7'b1100011, 3'd3, 7'h00}, {7'b1100011, 3'd4, 7'h00},
        {7'b1100011, 3'd5, 7'h00}, {7'b1100011, 3'd6, 7'h00}, {7'b1100011, 3'd7, 7'h00},
        {7'b1101111, 3'd0, 7'h00}, {7'b1100111, 3'd0, 7'h00}, {7'b0110111, 3'd0, 7'h00},
        {7'b0010111, 3'd0, 7'h00}, {7'b1111111, 3'd0, 7'h00}, {7'b0001111, 3'd0, 7'h00},
        {7'b0110011, 3'd7, 7'h01}, {7'b1100011, 3'd1, 7'h00}
    };

    initial begin
        rst = 1'b1; flush_e = 1'b0; zero_e = 1'b0; lt_e = 1'b0; ltu_e = 1'b0;
        drive(7'd0, 3'd0, 7'd0);
        tick(); tick();
        chk("lit_rst_IllegalE", IllegalE, 0);
        chk("lit_rst_RegWriteW", RegWriteW, 0);

        // Release with Op=0: E sees an illegal bubble.
        rst = 1'b0;
        tick();
        chk("lit_rel_IllegalE", IllegalE, 1);
        chk("lit_rel_RegWriteE", RegWriteE, 0);
        chk("lit_rel_ALUControlE", ALUControlE, 0);

        // Load latency through E, M, W.
        drive(7'b0000011, 3'd2, 7'd0);
        tick();
        drive(7'b0010011, 3'd0, 7'd0);
        chk("lit_ld_ResultSrcE", ResultSrcE, 1);
        tick();
        chk("lit_ld_ResultSrcM", ResultSrcM, 1);
        tick();
        chk("lit_ld_RegWriteW", RegWriteW, 1);
        chk("lit_ld_ResultSrcW", ResultSrcW, 1);

        // bne resolved in E against zero_e; then a flushed bne.
        drive(7'b1100011, 3'd1, 7'd0);
        tick();
        drive(7'b0010011, 3'd0, 7'd0);
        zero_e = 1'b0; #1;
        chk("lit_bne_taken", PCSrcE, 1);
        zero_e = 1'b1; #1;
        chk("lit_bne_not_taken", PCSrcE, 0);
        drive(7'b1100011, 3'd1, 7'd0);
        zero_e = 1'b0; flush_e = 1'b1;
        tick();
        flush_e = 1'b0;
        drive(7'b0010011, 3'd0, 7'd0);
        #1;
        chk("lit_bne_flushed", PCSrcE, 0);
        chk("lit_bne_flushed_BranchE", BranchE, 0);

        // SUB and the RV32M encoding.
        drive(7'b0110011, 3'd0, 7'h20);
        tick();
        chk("lit_sub_ALUControlE", ALUControlE, 1);
        drive(7'b0110011, 3'd0, 7'h01);
        tick();
`ifdef CTRL_MULDIV_EN
        chk("lit_mul_ALUControlE", ALUControlE, 16);
        chk("lit_mul_RegWriteE", RegWriteE, 1);
`else
        chk("lit_mul_IllegalE", IllegalE, 1);
        chk("lit_mul_RegWriteE", RegWriteE, 0);
`endif

        // Store in E, then reset together with flush.
        drive(7'b0100011, 3'd2, 7'd0);
        tick();
        chk("lit_st_MemWriteE", MemWriteE, 1);
        rst = 1'b1; flush_e = 1'b1;
        tick();
        rst = 1'b0; flush_e = 1'b0;
        chk("lit_rf_MemWriteM", MemWriteM, 0);
        chk("lit_rf_MemWriteE", MemWriteE, 0);
        chk("lit_rf_IllegalE", IllegalE, 0);
        chk("lit_rf_RegWriteW", RegWriteW, 0);
        chk("lit_rf_ResultSrcM", ResultSrcM, 0);

        // Instruction sweep with varying flags and periodic flushes.
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < NV; i++) begin
                logic [16:0] v;
                v = VEC[i];
                drive(v[16:10], v[9:7], v[6:0]);
                flush_e = ((i + pass) % 7 == 3);
                zero_e  = i[0] ^ pass[0];
                lt_e    = i[1];
                ltu_e   = i[2] ^ pass[0];
                tick();
            end
        end
        flush_e = 1'b0;
        drive(7'b0010011, 3'd0, 7'd0);
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/control_pipe.md
CONTROL_PIPE -- requirements
Module: control_pipe

Interface
REQ-001 Parameter ALUCTRL_W, default 5, ALUControl width; SHALL be >=5, upper bits above bit 4 driven 0.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 Op, funct3, funct7  in  7/3/7  decode-stage instruction fields.
REQ-005 flush_e  in  1  insert bubble into E stage next edge.
REQ-006 zero_e, lt_e, ltu_e  in  1 each  E-stage ALU compare flags (equal, signed less, unsigned less).
REQ-007 ImmSrcD  out  3  combinational: 0 I, 1 S, 2 B, 3 J, 4 U.
REQ-008 RegWriteE/M/W, MemWriteE/M, ResultSrcE/M/W (2b: 0 ALU, 1 mem, 2 PC+4), ALUSrcE, ALUSrcAE (1 = PC), ALUControlE, BranchE, JumpE, IllegalE  out  registered stage controls.
REQ-009 PCSrcE  out  1  combinational redirect from E-stage state and flags.

Function
REQ-010 Decode SHALL map Op: 0110011 R-ALU, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC.
REQ-011 ALU codes SHALL be ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9, PASSB 10.
REQ-012 R-type SUB/SRA SHALL require funct7=0100000; other R ops funct7=0000000; SRAI requires funct7=0100000, SLLI/SRLI 0000000.
REQ-013 Load/store/JALR/AUIPC SHALL use ADD; branch SHALL use SUB; LUI SHALL use PASSB with ALUSrcE=1.
REQ-014 Load: ResultSrc=1, RegWrite=1; store: MemWrite=1, RegWrite=0; JAL/JALR: Jump=1, ResultSrc=2, RegWrite=1.
REQ-015 Unlisted Op, bad funct7, or branch funct3 010/011 SHALL decode as bubble (all enables 0) with Illegal=1.
REQ-016 D->E, E->M, M->W registers SHALL each add exactly one cycle; funct3 SHALL be registered into E for branch evaluation.
REQ-017 flush_e=1 SHALL load E register with bubble (all fields 0, IllegalE=0) regardless of decode inputs.
REQ-018 M and W registers SHALL advance every cycle; a bubble in E propagates as bubble.
REQ-019 PCSrcE SHALL equal JumpE OR (BranchE AND cond), cond per funct3E: 000 zero_e, 001 !zero_e, 100 lt_e, 101 !lt_e, 110 ltu_e, 111 !ltu_e.
REQ-020 PCSrcE SHALL be 0 whenever E holds a bubble.

Reset
REQ-021 rst=1 SHALL clear every E/M/W register to bubble (all outputs 0, ResultSrc=0, ALUControl=0) at next edge.
REQ-022 rst SHALL take precedence over flush_e; in-flight controls SHALL be discarded, no partial writes.
REQ-023 ImmSrcD SHALL remain purely combinational and unaffected by rst.

Configuration
REQ-024 Macro CTRL_MULDIV_EN defined: R-type funct7=0000001 SHALL decode RV32M, ALUControl=16+funct3, RegWrite=1.
REQ-025 Macro CTRL_MULDIV_EN undefined: funct7=0000001 on R-type SHALL decode as illegal bubble per REQ-015.

Verification
REQ-026 rst held 2 cycles then released with Op=0 -> all stage outputs 0, IllegalE=1 one cycle after release.
REQ-027 Op=0000011 at cycle N -> ResultSrcE=1 at N+1, ResultSrcM=1 at N+2, RegWriteW=1 and ResultSrcW=1 at N+3.
REQ-028 Op=1100011, funct3=001, then zero_e=0 in E -> PCSrcE=1; zero_e=1 -> PCSrcE=0; flush_e same cycle as decode -> PCSrcE=0.
REQ-029 Op=0110011, funct3=000, funct7=0100000 -> ALUControlE=1; funct7=0000001 -> ALUControlE=16 with CTRL_MULDIV_EN, IllegalE=1 and RegWriteE=0 without.
REQ-030 Store in E with rst and flush_e both asserted -> MemWriteM=0 next cycle, all registers 0.
